// File: rtl/wb_pkg.sv
// Shared constants for the writeback arbiter.
// The requester indices also set the round-robin search order: LSU, then MDU, then ALU.
package wb_pkg;
   localparam int NUM_REQ      = 3;
   localparam int REG_ADDR_W   = 5;
   localparam int NUM_REGS     = 1 << REG_ADDR_W;
   localparam int XLEN_DEFAULT = 32;

   typedef logic [1:0]         req_idx_t;
   typedef logic [NUM_REQ-1:0] req_vec_t;

   localparam req_idx_t REQ_LSU = 2'd0;
   localparam req_idx_t REQ_MDU = 2'd1;
   localparam req_idx_t REQ_ALU = 2'd2;

   function automatic req_idx_t next_req(input req_idx_t idx);
      return (idx == REQ_ALU) ? REQ_LSU : req_idx_t'(idx + 2'd1);
   endfunction
endpackage

// File: rtl/wb_grant_arb.sv
// One-hot grant from a valid vector: zero latency, a request is held until it is granted.
// WB_ARB_RR_EN selects a round-robin pointer; without it the grant is fixed priority LSU > MDU > ALU.
module wb_grant_arb
   import wb_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  req_vec_t req_vld,
   output req_vec_t gnt
);

`ifdef WB_ARB_RR_EN
   req_idx_t ptr_q, ptr_d;
   req_idx_t scan_idx;
   logic     found;

   // Walk the ring once starting at the pointer; the first valid requester wins.
   always_comb begin
      gnt      = '0;
      ptr_d    = ptr_q;
      scan_idx = ptr_q;
      found    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_vld[scan_idx]) begin
            gnt[scan_idx] = 1'b1;
            ptr_d         = next_req(scan_idx);
            found         = 1'b1;
         end
         scan_idx = next_req(scan_idx);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= REQ_LSU;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;

   always_comb begin
      gnt = '0;
      if (req_vld[REQ_LSU]) begin
         gnt[REQ_LSU] = 1'b1;
      end else if (req_vld[REQ_MDU]) begin
         gnt[REQ_MDU] = 1'b1;
      end else if (req_vld[REQ_ALU]) begin
         gnt[REQ_ALU] = 1'b1;
      end
   end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: combinational grant to LSU/MDU/ALU, registered RF write one cycle later,
// plus a busy scoreboard for long-latency destinations. WB_ARB_RR_EN enables round-robin grant.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   output logic                  alu_ready,
   input  logic                  lsu_valid,
   input  logic [REG_ADDR_W-1:0] lsu_rd,
   input  logic [XLEN-1:0]       lsu_data,
   output logic                  lsu_ready,
   input  logic                  mdu_valid,
   input  logic [REG_ADDR_W-1:0] mdu_rd,
   input  logic [XLEN-1:0]       mdu_data,
   output logic                  mdu_ready,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic                  issue_long,
   input  logic [REG_ADDR_W-1:0] dec_rs1,
   input  logic [REG_ADDR_W-1:0] dec_rs2,
   input  logic [REG_ADDR_W-1:0] dec_rd,
   output logic                  hazard_stall,
   output logic [REG_ADDR_W-1:0] rd,
   output logic [XLEN-1:0]       wb_data,
   output logic                  wb_reg_write
);

   req_vec_t              req_vld;
   req_vec_t              gnt;
   logic [REG_ADDR_W-1:0] sel_rd;
   logic [XLEN-1:0]       sel_data;
   logic                  acc;
   logic                  acc_long;

   logic [REG_ADDR_W-1:0] rd_q, rd_d;
   logic [XLEN-1:0]       wb_data_q, wb_data_d;
   logic                  wb_reg_write_q, wb_reg_write_d;
   logic [NUM_REGS-1:0]   busy_q, busy_d;

   // Requests are masked during reset so nothing is consumed in that cycle.
   always_comb begin
      req_vld = '0;
      if (!rst) begin
         req_vld[REQ_LSU] = lsu_valid;
         req_vld[REQ_MDU] = mdu_valid;
         req_vld[REQ_ALU] = alu_valid;
      end
   end

   wb_grant_arb u_grant_arb (
      .clk     (clk),
      .rst     (rst),
      .req_vld (req_vld),
      .gnt     (gnt)
   );

   assign lsu_ready = gnt[REQ_LSU];
   assign mdu_ready = gnt[REQ_MDU];
   assign alu_ready = gnt[REQ_ALU];

   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      if (gnt[REQ_LSU]) begin
         sel_rd   = lsu_rd;
         sel_data = lsu_data;
      end else if (gnt[REQ_MDU]) begin
         sel_rd   = mdu_rd;
         sel_data = mdu_data;
      end else if (gnt[REQ_ALU]) begin
         sel_rd   = alu_rd;
         sel_data = alu_data;
      end
   end

   assign acc      = |gnt;
   assign acc_long = gnt[REQ_LSU] | gnt[REQ_MDU];

   // A new long issue to the same register as a retiring result must stay busy, so set follows clear.
   always_comb begin
      wb_reg_write_d = acc && (sel_rd != '0);
      rd_d           = acc ? sel_rd : rd_q;
      wb_data_d      = acc ? sel_data : wb_data_q;
      busy_d         = busy_q;
      if (acc_long) begin
         busy_d[sel_rd] = 1'b0;
      end
      if (issue_valid && issue_long) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q           <= '0;
         wb_data_q      <= '0;
         wb_reg_write_q <= 1'b0;
         busy_q         <= '0;
      end else begin
         rd_q           <= rd_d;
         wb_data_q      <= wb_data_d;
         wb_reg_write_q <= wb_reg_write_d;
         busy_q         <= busy_d;
      end
   end

   assign hazard_stall = busy_q[dec_rs1] | busy_q[dec_rs2] | busy_q[dec_rd];
   assign rd           = rd_q;
   assign wb_data      = wb_data_q;
   assign wb_reg_write = wb_reg_write_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: grant order, writeback timing, scoreboard and reset behaviour.
module tb_wb_arbiter;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_exp_t;

   logic        clk;
   logic        rst;
   logic        alu_valid, lsu_valid, mdu_valid;
   logic [4:0]  alu_rd, lsu_rd, mdu_rd;
   logic [31:0] alu_data, lsu_data, mdu_data;
   logic        alu_ready, lsu_ready, mdu_ready;
   logic        issue_valid, issue_long;
   logic [4:0]  issue_rd;
   logic [4:0]  dec_rs1, dec_rs2, dec_rd;
   logic        hazard_stall;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_reg_write;

   int      errors = 0;
   int      checks = 0;
   wb_exp_t sb[$];

   wb_arbiter #(.XLEN(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .alu_valid    (alu_valid),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .alu_ready    (alu_ready),
      .lsu_valid    (lsu_valid),
      .lsu_rd       (lsu_rd),
      .lsu_data     (lsu_data),
      .lsu_ready    (lsu_ready),
      .mdu_valid    (mdu_valid),
      .mdu_rd       (mdu_rd),
      .mdu_data     (mdu_data),
      .mdu_ready    (mdu_ready),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .issue_long   (issue_long),
      .dec_rs1      (dec_rs1),
      .dec_rs2      (dec_rs2),
      .dec_rd       (dec_rd),
      .hazard_stall (hazard_stall),
      .rd           (wb_rd),
      .wb_data      (wb_data),
      .wb_reg_write (wb_reg_write)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   // Expected writeback for a grant vector {alu, mdu, lsu}, from the values the bench drove.
   function automatic wb_exp_t exp_of(input logic [2:0] g);
      wb_exp_t e;
      e = '0;
      if (g[0]) begin
         e.rd = lsu_rd; e.data = lsu_data;
      end else if (g[1]) begin
         e.rd = mdu_rd; e.data = mdu_data;
      end else if (g[2]) begin
         e.rd = alu_rd; e.data = alu_data;
      end
      e.we = (g != 3'b000) && (e.rd != 5'd0);
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      lsu_valid = 1'b1; mdu_valid = 1'b1; alu_valid = 1'b1;
      lsu_rd = 5'd1; mdu_rd = 5'd2; alu_rd = 5'd3;
      step();
      step();
      @(negedge clk);
      checks++;
      if ({alu_ready, mdu_ready, lsu_ready} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ready: got %b required 000", {alu_ready, mdu_ready, lsu_ready});
      end
      checks++;
      if ({wb_reg_write, wb_rd, wb_data} !== 38'd0) begin
         errors++;
         $display("FAIL reset_out: got we=%b rd=%0d data=%h required all zero", wb_reg_write, wb_rd, wb_data);
      end
      checks++;
      if (hazard_stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_stall: got %b required 0", hazard_stall);
      end
      step();
      rst = 1'b0;
      lsu_valid = 1'b0; mdu_valid = 1'b0; alu_valid = 1'b0;
   endtask

   // Rows: requesters raised this cycle {alu,mdu,lsu} and the grant required.
   task automatic test_fixed_priority();
      logic [2:0] raise_tab [0:6];
      logic [2:0] exp_tab   [0:6];
      wb_exp_t    e;
      raise_tab = '{3'b111, 3'b000, 3'b000, 3'b000, 3'b110, 3'b000, 3'b001};
      exp_tab   = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b010, 3'b100, 3'b001};
      lsu_rd = 5'd2; mdu_rd = 5'd3; alu_rd = 5'd4;
      for (int k = 0; k < 7; k++) begin
         if (raise_tab[k][0]) begin
            lsu_valid = 1'b1; lsu_rd = lsu_rd + 5'd3; lsu_data = 32'h1100_0000 | 32'(k);
         end
         if (raise_tab[k][1]) begin
            mdu_valid = 1'b1; mdu_rd = mdu_rd + 5'd3; mdu_data = 32'h2200_0000 | 32'(k);
         end
         if (raise_tab[k][2]) begin
            alu_valid = 1'b1; alu_rd = alu_rd + 5'd3; alu_data = 32'h3300_0000 | 32'(k);
         end
         @(negedge clk);
         checks++;
         if ({alu_ready, mdu_ready, lsu_ready} !== exp_tab[k]) begin
            errors++;
            $display("FAIL prio_grant[%0d]: got %b required %b", k, {alu_ready, mdu_ready, lsu_ready}, exp_tab[k]);
         end
         sb.push_back(exp_of(exp_tab[k]));
         step();
         e = sb.pop_front();
         checks++;
         if (wb_reg_write !== e.we) begin
            errors++;
            $display("FAIL prio_we[%0d]: got %b required %b", k, wb_reg_write, e.we);
         end
         if (e.we) begin
            checks++;
            if ({wb_rd, wb_data} !== {e.rd, e.data}) begin
               errors++;
               $display("FAIL prio_wb[%0d]: got rd=%0d data=%h required rd=%0d data=%h", k, wb_rd, wb_data, e.rd, e.data);
            end
         end
         if (exp_tab[k][0]) lsu_valid = 1'b0;
         if (exp_tab[k][1]) mdu_valid = 1'b0;
         if (exp_tab[k][2]) alu_valid = 1'b0;
      end
   endtask

   task automatic test_scoreboard();
      wb_exp_t e;
      issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9;
      dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
      step();
      issue_valid = 1'b0; dec_rs1 = 5'd9;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_A1A1;
      @(negedge clk);
      checks++;
      if (hazard_stall !== 1'b1 || alu_ready !== 1'b1) begin
         errors++;
         $display("FAIL sb_set: got stall=%b alu_ready=%b required 1 1", hazard_stall, alu_ready);
      end
      sb.push_back(exp_of(3'b100));
      step();
      alu_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({wb_reg_write, wb_rd, wb_data} !== {e.we, e.rd, e.data}) begin
         errors++;
         $display("FAIL sb_alu_wb: got we=%b rd=%0d data=%h required we=%b rd=%0d data=%h", wb_reg_write, wb_rd, wb_data, e.we, e.rd, e.data);
      end
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h0000_B2B2;
      @(negedge clk);
      checks++;
      if (hazard_stall !== 1'b1 || lsu_ready !== 1'b1) begin
         errors++;
         $display("FAIL sb_alu_noclear: got stall=%b lsu_ready=%b required 1 1", hazard_stall, lsu_ready);
      end
      sb.push_back(exp_of(3'b001));
      step();
      lsu_valid = 1'b0;
      issue_valid = 1'b1; issue_long = 1'b0; issue_rd = 5'd9;
      e = sb.pop_front();
      checks++;
      if ({wb_reg_write, wb_rd, wb_data} !== {e.we, e.rd, e.data}) begin
         errors++;
         $display("FAIL sb_lsu_wb: got we=%b rd=%0d data=%h required we=%b rd=%0d data=%h", wb_reg_write, wb_rd, wb_data, e.we, e.rd, e.data);
      end
      @(negedge clk);
      checks++;
      if (hazard_stall !== 1'b0) begin
         errors++;
         $display("FAIL sb_clear: got stall=%b required 0", hazard_stall);
      end
      step();
      issue_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (hazard_stall !== 1'b0) begin
         errors++;
         $display("FAIL sb_short_issue: got stall=%b required 0", hazard_stall);
      end
      step();
      dec_rs1 = 5'd0;
   endtask

   task automatic test_set_clear_same();
      wb_exp_t e;
      issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd3;
      step();
      mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'h0000_C3C3;
      dec_rs2 = 5'd3;
      @(negedge clk);
      checks++;
      if (mdu_ready !== 1'b1 || hazard_stall !== 1'b1) begin
         errors++;
         $display("FAIL sc_accept: got mdu_ready=%b stall=%b required 1 1", mdu_ready, hazard_stall);
      end
      sb.push_back(exp_of(3'b010));
      step();
      issue_valid = 1'b0; mdu_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({wb_reg_write, wb_rd, wb_data} !== {e.we, e.rd, e.data}) begin
         errors++;
         $display("FAIL sc_wb: got we=%b rd=%0d data=%h required we=%b rd=%0d data=%h", wb_reg_write, wb_rd, wb_data, e.we, e.rd, e.data);
      end
      @(negedge clk);
      checks++;
      if (hazard_stall !== 1'b1) begin
         errors++;
         $display("FAIL sc_set_wins_rs2: got stall=%b required 1", hazard_stall);
      end
      dec_rs2 = 5'd0; dec_rd = 5'd3;
      #1;
      checks++;
      if (hazard_stall !== 1'b1) begin
         errors++;
         $display("FAIL sc_set_wins_rd: got stall=%b required 1", hazard_stall);
      end
      step();
      mdu_valid = 1'b1;
      step();
      mdu_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (hazard_stall !== 1'b0) begin
         errors++;
         $display("FAIL sc_final_clear: got stall=%b required 0", hazard_stall);
      end
      step();
      dec_rd = 5'd0;
   endtask

   task automatic test_rd_zero();
      wb_exp_t e;
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++;
      if (alu_ready !== 1'b1) begin
         errors++;
         $display("FAIL rd0_ready: got %b required 1", alu_ready);
      end
      sb.push_back(exp_of(3'b100));
      step();
      alu_valid = 1'b0;
      issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd0;
      e = sb.pop_front();
      checks++;
      if (wb_reg_write !== e.we) begin
         errors++;
         $display("FAIL rd0_we: got %b required %b", wb_reg_write, e.we);
      end
      step();
      issue_valid = 1'b0; dec_rs1 = 5'd0;
      @(negedge clk);
      checks++;
      if (hazard_stall !== 1'b0) begin
         errors++;
         $display("FAIL rd0_stall: got %b required 0", hazard_stall);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_tab [0:3];
      wb_exp_t    e;
`ifdef WB_ARB_RR_EN
      exp_tab = '{3'b001, 3'b100, 3'b001, 3'b100};
`else
      exp_tab = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
      rst = 1'b1;
      step();
      rst = 1'b0;
      lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h5555_0014;
      alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'h7777_0015;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if ({alu_ready, mdu_ready, lsu_ready} !== exp_tab[k]) begin
            errors++;
            $display("FAIL b2b_grant[%0d]: got %b required %b", k, {alu_ready, mdu_ready, lsu_ready}, exp_tab[k]);
         end
         sb.push_back(exp_of(exp_tab[k]));
         step();
         e = sb.pop_front();
         checks++;
         if ({wb_reg_write, wb_rd, wb_data} !== {e.we, e.rd, e.data}) begin
            errors++;
            $display("FAIL b2b_wb[%0d]: got we=%b rd=%0d data=%h required we=%b rd=%0d data=%h", k, wb_reg_write, wb_rd, wb_data, e.we, e.rd, e.data);
         end
      end
      lsu_valid = 1'b0; alu_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      wb_exp_t e;
      issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd4;
      step();
      issue_valid = 1'b0; dec_rs1 = 5'd4;
      lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'h0000_0B0B;
      @(negedge clk);
      checks++;
      if (hazard_stall !== 1'b1 || lsu_ready !== 1'b1) begin
         errors++;
         $display("FAIL rm_pre: got stall=%b lsu_ready=%b required 1 1", hazard_stall, lsu_ready);
      end
      sb.push_back(exp_of(3'b001));
      step();
      rst = 1'b1;
      lsu_rd = 5'd12; lsu_data = 32'h0000_0C0C;
      e = sb.pop_front();
      checks++;
      if ({wb_reg_write, wb_rd, wb_data} !== {e.we, e.rd, e.data}) begin
         errors++;
         $display("FAIL rm_wb: got we=%b rd=%0d data=%h required we=%b rd=%0d data=%h", wb_reg_write, wb_rd, wb_data, e.we, e.rd, e.data);
      end
      @(negedge clk);
      checks++;
      if (lsu_ready !== 1'b0) begin
         errors++;
         $display("FAIL rm_ready: got %b required 0", lsu_ready);
      end
      step();
      rst = 1'b0; lsu_valid = 1'b0;
      checks++;
      if ({wb_reg_write, wb_rd, wb_data} !== 38'd0) begin
         errors++;
         $display("FAIL rm_out: got we=%b rd=%0d data=%h required all zero", wb_reg_write, wb_rd, wb_data);
      end
      checks++;
      if (hazard_stall !== 1'b0) begin
         errors++;
         $display("FAIL rm_busy: got stall=%b required 0", hazard_stall);
      end
   endtask

   initial begin
      rst = 1'b1;
      alu_valid = 1'b0; lsu_valid = 1'b0; mdu_valid = 1'b0;
      alu_rd = '0; lsu_rd = '0; mdu_rd = '0;
      alu_data = '0; lsu_data = '0; mdu_data = '0;
      issue_valid = 1'b0; issue_long = 1'b0; issue_rd = '0;
      dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
      test_reset();
      test_fixed_priority();
      test_scoreboard();
      test_set_clear_same();
      test_rd_zero();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32: width of every writeback data path.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 alu_valid/lsu_valid/mdu_valid  in  1 each  requester has a result pending.
REQ-005 alu_rd/lsu_rd/mdu_rd  in  5 each  destination register of the pending result.
REQ-006 alu_data/lsu_data/mdu_data  in  XLEN each  result value.
REQ-007 alu_ready/lsu_ready/mdu_ready  out  1 each  grant; the result is consumed on the cycle where valid && ready.
REQ-008 issue_valid  in  1  decode issues an instruction this cycle.
REQ-009 issue_rd  in  5  destination of the issued instruction.
REQ-010 issue_long  in  1  the issued instruction goes to LSU or MDU (multi-cycle).
REQ-011 dec_rs1/dec_rs2/dec_rd  in  5 each  operands of the instruction in decode.
REQ-012 hazard_stall  out  1  decode must hold (scoreboard hit).
REQ-013 rd  out  5, wb_data  out  XLEN, wb_reg_write  out  1  registered register-file write port.

Function
REQ-014 At most one ready is high per cycle; ready is high only for a requester whose valid is high.
REQ-015 Default arbitration is fixed priority: LSU > MDU > ALU.
REQ-016 A non-granted requester holds valid, rd and data stable until granted; the arbiter never drops a request.
REQ-017 Latency: a result accepted in cycle N drives rd/wb_data with wb_reg_write=1 in cycle N+1 exactly one cycle; with no acceptance, wb_reg_write=0 in cycle N+1.
REQ-018 An accepted result with rd==0 is consumed but produces wb_reg_write=0.
REQ-019 Scoreboard: 32 busy bits; busy[issue_rd] sets on issue_valid && issue_long && issue_rd!=0.
REQ-020 busy[x] clears on the cycle an LSU or MDU result with rd==x is accepted; ALU acceptances never clear busy bits.
REQ-021 Same-cycle set and clear of one index: set wins; busy[0] is always 0.
REQ-022 hazard_stall = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd], combinational from current busy state; in-flight-cycle clears are not bypassed.
REQ-023 Arbitration is purely combinational from valids (and round-robin pointer when REQ-027 applies); no idle cycle between back-to-back grants.

Reset
REQ-024 While rst is high at posedge: wb_reg_write=0, rd=0, wb_data=0, all busy bits=0, round-robin pointer=LSU.
REQ-025 Requests present in the reset cycle are not consumed (all ready=0 while rst high); a result accepted the cycle before reset is still cleared from the output register by reset.

Configuration
REQ-026 Macro WB_ARB_RR_EN selects arbitration policy.
REQ-027 With WB_ARB_RR_EN defined: round-robin in order LSU, MDU, ALU; search starts at pointer; after a grant the pointer moves to the requester following the granted one; no grant leaves the pointer unchanged.
REQ-028 Without WB_ARB_RR_EN: fixed priority per REQ-015, no pointer state.

Structure
REQ-029 Shared package wb_pkg holds NUM_REQ=3, REQ_LSU=0, REQ_MDU=1, REQ_ALU=2, REG_ADDR_W=5 and the default XLEN.
REQ-030 Grant logic is the sub-module wb_grant_arb (valid vector in, one-hot grant out, optional pointer state); scoreboard and output register stay in wb_arbiter.

Verification
REQ-031 All three valid in one cycle, rd=5/6/7, fixed priority -> lsu_ready=1; next cycle rd=5, wb_reg_write=1; mdu then alu granted on the following two cycles.
REQ-032 issue_valid=1, issue_long=1, issue_rd=9; next cycle dec_rs1=9 -> hazard_stall=1; lsu result rd=9 accepted -> stall drops the following cycle.
REQ-033 Same cycle: issue_long to rd=3 and an MDU result to rd=3 accepted -> busy[3] remains 1, hazard_stall=1 for dec_rs2=3.
REQ-034 ALU result rd=0, data 0xDEADBEEF -> alu_ready=1, next cycle wb_reg_write=0; issue_long to rd=0 -> no stall for dec_rs1=0.
REQ-035 WB_ARB_RR_EN defined, LSU and ALU valid continuously -> grants alternate LSU, ALU, LSU, ALU.
REQ-036 rst asserted with busy[4]=1 and lsu_valid=1 -> lsu_ready=0, next cycle busy cleared, wb_reg_write=0, rd=0.
